msg_encrypter: RTL and testbench
================================

MSG_ENCRYPTER -- requirements
Module: msg_encrypter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MSG_BASE, 0, plaintext base address.
- CT_BASE, 64, ciphertext base address.
- FRAME_LEN, 64, ciphertext bytes per frame.
- PAD_CHAR, 8'h5F, preamble character.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be, in this order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- init  in  1  asynchronous active-high reset.
- start  in  1  request an encryption frame.
- pat_sel  in  3  tap-pattern index 0..5 (6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39).
- seed  in  6  LFSR starting state.
- pre_len  in  4  preamble length in characters.
- raddr  out  8  memory read address.
- data_out  in  8  memory read data, combinational, same-cycle valid.
- waddr  out  8  memory write address.
- data_in  out  8  memory write data.
- wr_en  out  1  memory write strobe.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
- err  out  1  one-cycle rejected-request pulse.

Function
REQ-004 The state machine SHALL have states IDLE, LOAD, PREAMBLE, BODY and FIN.
REQ-005 In IDLE, start=1 SHALL latch pat_sel, seed and pre_len at the clock edge.
REQ-006 In IDLE, a start with pat_sel>5 or seed==0 SHALL pulse err for one cycle, perform no writes, and leave the state at IDLE.
REQ-007 The latched pre_len SHALL be clamped to 7..12 (values below 7 become 7, values above 12 become 12).
REQ-008 LOAD SHALL last one cycle and load the LFSR with seed; wr_en SHALL be 0 in LOAD.
REQ-009 Output byte k (k = 0..FRAME_LEN-1) SHALL be written to CT_BASE+k, one byte per cycle, with wr_en high for exactly FRAME_LEN consecutive cycles starting the cycle after LOAD.
REQ-010 The LFSR SHALL follow lfsr_0 = seed and lfsr_(k+1) = {lfsr_k[4:0], ^(lfsr_k & taps)}, and advance once per write.
REQ-011 Plain byte p_k SHALL be PAD_CHAR in PREAMBLE (k < pre_len) and data_out read at MSG_BASE+(k-pre_len) in BODY.
REQ-012 data_in SHALL equal p_k ^ {2'b00, lfsr_k}; the upper two plaintext bits pass through unmodified.
REQ-013 raddr SHALL present MSG_BASE+(k-pre_len) in the same cycle as write k during BODY, and SHALL be MSG_BASE otherwise.
REQ-014 Addresses SHALL be 8-bit unsigned, and the final write address SHALL be CT_BASE+FRAME_LEN-1 with no wrap.
REQ-015 After the last write the state SHALL go to FIN; done=1 for one cycle, then IDLE.
REQ-016 busy SHALL be 1 in LOAD, PREAMBLE, BODY and FIN, and 0 in IDLE.
REQ-017 start SHALL be ignored while busy.
REQ-018 A start held high SHALL begin a new frame on the cycle after FIN, back to back.
REQ-019 Total latency from the start-sampling edge to the done pulse SHALL be FRAME_LEN+2 cycles.

Reset
REQ-020 init=1 SHALL force IDLE immediately, without waiting for a clock edge.
REQ-021 On reset, wr_en, busy, done and err SHALL be 0; raddr SHALL be MSG_BASE; waddr SHALL be CT_BASE; data_in and the LFSR SHALL be 0.
REQ-022 Reset during a frame SHALL abort it; bytes already written stay in memory and are not rewritten.
REQ-023 Deassertion of init SHALL be synchronized to clk before the state machine leaves IDLE.

Structure
REQ-024 A shared package SHALL hold the state enum, the six tap constants as an array indexed by pat_sel, and PAD_CHAR.
REQ-025 The LFSR SHALL be one instance of the existing lfsr6b sub-module (clk, en, init, taps, start, state).
REQ-026 Byte counting, addressing and the XOR datapath SHALL be in msg_encrypter.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then seed=6'h01, pat_sel=0, pre_len=8, start -> mem[64..70] = 5E,5C,58,50,40,60,61; done exactly 66 cycles after start.
- Round trip: each pat_sel 0..5 with random seed and a 56-byte message, then run the existing decrypter DUT -> mem[0..] equals the message.
- pat_sel=6 or seed=0 with start -> err pulses once, no wr_en, busy stays 0.
- pre_len=3 -> 7 pad bytes encrypted; pre_len=15 -> 12 pad bytes encrypted.
- init asserted at write 30 -> outputs reset asynchronously; mem[94..127] unchanged; a later start completes normally.
- start held high across FIN -> second frame begins with no idle cycle; start pulses during busy are ignored.

Source files
------------

// File: rtl/msg_encrypter_pkg.sv
// Shared definitions for the message encrypter: FSM states, LFSR tap table,
// preamble character and the preamble-length clamp.
package msg_encrypter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_BODY     = 3'd3,
    ST_FIN      = 3'd4
  } state_e;

  localparam int NUM_PATTERNS = 6;

  // Feedback tap masks, indexed by pat_sel.
  localparam logic [5:0] TAP_TABLE [NUM_PATTERNS] = '{
    6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39
  };

  localparam logic [7:0] PAD_CHAR_DEFAULT = 8'h5F;

  localparam logic [3:0] PRE_LEN_MIN = 4'd7;
  localparam logic [3:0] PRE_LEN_MAX = 4'd12;

  // Tap mask for a pattern index; out-of-range indices give an empty mask
  // (they are rejected before ever reaching the LFSR).
  function automatic logic [5:0] taps_for(input logic [2:0] sel);
    logic [5:0] t;
    t = 6'h00;
    if (sel < 3'd6) t = TAP_TABLE[sel];
    return t;
  endfunction

  // Preamble length limited to PRE_LEN_MIN..PRE_LEN_MAX.
  function automatic logic [3:0] clamp_pre_len(input logic [3:0] len);
    logic [3:0] r;
    r = len;
    if (len < PRE_LEN_MIN) r = PRE_LEN_MIN;
    else if (len > PRE_LEN_MAX) r = PRE_LEN_MAX;
    return r;
  endfunction

endpackage

// File: rtl/lfsr6b.sv
// 6-bit Fibonacci-style LFSR. While enabled it shifts left and feeds back
// the parity of (state & taps); while disabled it loads 'start', so the
// owner can park it at zero or preload a seed.
module lfsr6b (
  input  logic       clk,
  input  logic       en,
  input  logic       init,
  input  logic [5:0] taps,
  input  logic [5:0] start,
  output logic [5:0] state
);

  logic [5:0] state_q, state_d;

  // Next state: advance when enabled, otherwise take the start value.
  always_comb begin
    state_d = start;
    if (en) state_d = {state_q[4:0], ^(state_q & taps)};
  end

  // State register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge init) begin
    if (init) state_q <= 6'h00;
    else      state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/msg_encrypter.sv
// Frame encrypter: writes FRAME_LEN ciphertext bytes starting at CT_BASE.
// The first pre_len (clamped) bytes are PAD_CHAR, the rest are read from
// MSG_BASE onwards; every byte has its low six bits XORed with an LFSR.
module msg_encrypter
  import msg_encrypter_pkg::*;
#(
  parameter logic [7:0] MSG_BASE  = 8'd0,
  parameter logic [7:0] CT_BASE   = 8'd64,
  parameter int         FRAME_LEN = 64,
  parameter logic [7:0] PAD_CHAR  = PAD_CHAR_DEFAULT
) (
  input  logic       clk,
  input  logic       init,
  input  logic       start,
  input  logic [2:0] pat_sel,
  input  logic [5:0] seed,
  input  logic [3:0] pre_len,
  output logic [7:0] raddr,
  input  logic [7:0] data_out,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  // Internal reset: asserts together with init, releases two clocks later.
  logic rst_meta_q, rst_q;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] taps_q, taps_d;
  logic [5:0] seed_q, seed_d;
  logic [3:0] pre_len_q, pre_len_d;

  logic       req_ok;
  logic       can_accept;
  logic       writing;
  logic       in_body;
  logic [7:0] body_off;
  logic [7:0] plain;
  logic [5:0] lfsr_state;
  logic [5:0] lfsr_start;

  // Reset synchronizer: asynchronous assertion, clock-aligned release.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  assign req_ok     = (pat_sel <= 3'd5) && (seed != 6'd0);
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_FIN);
  assign writing    = (state_q == ST_PREAMBLE) || (state_q == ST_BODY);
  assign in_body    = (state_q == ST_BODY);

  // Next-state, byte counter and request latching.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    taps_d    = taps_q;
    seed_d    = seed_q;
    pre_len_d = pre_len_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        // FIN accepts a new request too, so a held start runs back to back.
        state_d = ST_IDLE;
        if (start && req_ok) begin
          state_d   = ST_LOAD;
          taps_d    = taps_for(pat_sel);
          seed_d    = seed;
          pre_len_d = clamp_pre_len(pre_len);
        end
      end
      ST_LOAD: begin
        state_d = ST_PREAMBLE;
        cnt_d   = 8'd0;
      end
      ST_PREAMBLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == ({4'b0000, pre_len_q} - 8'd1)) state_d = ST_BODY;
      end
      ST_BODY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_FIN;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      taps_q    <= 6'h00;
      seed_q    <= 6'h00;
      pre_len_q <= PRE_LEN_MIN;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      taps_q    <= taps_d;
      seed_q    <= seed_d;
      pre_len_q <= pre_len_d;
    end
  end

  // Keystream: parked at zero, seeded during LOAD, stepped once per write.
  assign lfsr_start = (state_q == ST_LOAD) ? seed_q : 6'h00;

  lfsr6b u_lfsr (
    .clk   (clk),
    .en    (writing),
    .init  (rst_q),
    .taps  (taps_q),
    .start (lfsr_start),
    .state (lfsr_state)
  );

  // Addressing and XOR datapath.
  always_comb begin
    body_off = cnt_q - {4'b0000, pre_len_q};
    plain    = in_body ? data_out : PAD_CHAR;
    raddr    = in_body ? (MSG_BASE + body_off) : MSG_BASE;
    waddr    = writing ? (CT_BASE + cnt_q) : CT_BASE;
    data_in  = writing ? (plain ^ {2'b00, lfsr_state}) : 8'h00;
    wr_en    = writing;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_FIN);
    err      = !rst_q && can_accept && start && !req_ok;
  end

endmodule

// File: tb/tb_msg_encrypter.sv
// Randomized scoreboard bench for msg_encrypter with a behavioural memory.
module tb_msg_encrypter;

  localparam logic [7:0] MSG_BASE  = 8'd0;
  localparam logic [7:0] CT_BASE   = 8'd64;
  localparam int         FRAME_LEN = 64;
  localparam logic [7:0] PAD       = 8'h5F;
  localparam logic [5:0] TAP_TBL [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  logic       clk = 1'b0;
  logic       init, start;
  logic [2:0] pat_sel;
  logic [5:0] seed;
  logic [3:0] pre_len;
  logic [7:0] raddr, data_out, waddr, data_in;
  logic       wr_en, busy, done, err;

  logic [7:0] mem [256];
  logic [7:0] msg_buf [64];
  logic [7:0] ks [FRAME_LEN];
  int         last_plc;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  assign data_out = mem[raddr];

  msg_encrypter dut (
    .clk(clk), .init(init), .start(start), .pat_sel(pat_sel), .seed(seed),
    .pre_len(pre_len), .raddr(raddr), .data_out(data_out), .waddr(waddr),
    .data_in(data_in), .wr_en(wr_en), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic mem_writer();
    forever begin
      @(posedge clk);
      if (wr_en === 1'b1) mem[waddr] <= data_in;
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: waddr 0x%0h data 0x%0h, expected no write", waddr, data_in);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", waddr, e.wa);
          check("wr_data", data_in, e.wd);
          check("rd_addr", raddr, e.ra);
        end
      end
    end
  endtask

  // Reference model: one frame described directly from the byte rules.
  task automatic push_frame(input logic [2:0] ps, input logic [5:0] sd, input logic [3:0] pl);
    int plc;
    logic [5:0] l;
    logic [7:0] p;
    wr_t e;
    plc = (pl < 7) ? 7 : ((pl > 12) ? 12 : int'(pl));
    l = sd;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (k < plc) begin
        e.ra = MSG_BASE;
        p = PAD;
      end else begin
        e.ra = MSG_BASE + 8'(k - plc);
        p = mem[e.ra];
      end
      ks[k] = {2'b00, l};
      e.wa = CT_BASE + 8'(k);
      e.wd = p ^ ks[k];
      exp_q.push_back(e);
      l = {l[4:0], ^(l & TAP_TBL[ps])};
    end
    last_plc = plc;
  endtask

  task automatic fill_msg();
    for (int i = 0; i < 64; i++) begin
      msg_buf[i] = 8'($urandom);
      mem[i] = msg_buf[i];
    end
    for (int i = 64; i < 128; i++) mem[i] = 8'h00;
  endtask

  task automatic run_frame(input logic [2:0] ps, input logic [5:0] sd, input logic [3:0] pl,
                           input bit noise);
    int lat;
    bit seen, busy_ok;
    push_frame(ps, sd, pl);
    @(negedge clk);
    pat_sel = ps; seed = sd; pre_len = pl; start = 1'b1;
    lat = 0; seen = 0; busy_ok = 1;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (noise && lat == 20) begin
        pat_sel = 3'd6; seed = 6'd0; pre_len = 4'd15; start = 1'b1;
        #1 check("err_while_busy", err, 0);
      end
      if (noise && lat == 21) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles, expected %0d", lat, FRAME_LEN + 2);
    end else begin
      check("done_latency", lat, FRAME_LEN + 2);
    end
    check("busy_during_frame", busy_ok, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("frame pat_sel=%0d seed=0x%0h pre_len=%0d latency=%0d", ps, sd, pl, lat);
  endtask

  // Decrypt the ciphertext region with the model keystream.
  task automatic roundtrip_check(input int plc);
    int bad;
    logic [7:0] pt;
    bad = 0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      pt = mem[CT_BASE + 8'(k)] ^ ks[k];
      if (k < plc) begin
        if (pt !== PAD) bad++;
      end else if (k - plc < 56) begin
        if (pt !== msg_buf[k - plc]) bad++;
      end
    end
    check("roundtrip_bytes_bad", bad, 0);
  endtask

  task automatic err_request(input logic [2:0] ps, input logic [5:0] sd);
    bit saw_wr, saw_busy;
    @(negedge clk);
    pat_sel = ps; seed = sd; pre_len = 4'd8; start = 1'b1;
    #1 check("err_pulse", err, 1);
    check("err_busy_low", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #1 check("err_single_cycle", err, 0);
    saw_wr = 0; saw_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en !== 1'b0) saw_wr = 1;
      if (busy !== 1'b0) saw_busy = 1;
    end
    check("err_no_write", saw_wr, 0);
    check("err_no_busy", saw_busy, 0);
    $display("rejected request pat_sel=%0d seed=0x%0h", ps, sd);
  endtask

  task automatic abort_frame();
    int lat, bad;
    fill_msg();
    for (int i = 64; i < 128; i++) mem[i] = 8'hA5;
    push_frame(3'd1, 6'h2B, 4'd9);
    @(negedge clk);
    pat_sel = 3'd1; seed = 6'h2B; pre_len = 4'd9; start = 1'b1;
    lat = 0;
    while (lat < 32) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
    end
    check("abort_writing_before", wr_en, 1);
    check("abort_write30_addr", waddr, 8'd94);
    #2 init = 1'b1;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_raddr", raddr, MSG_BASE);
    check("abort_waddr", waddr, CT_BASE);
    check("abort_data_in", data_in, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    init = 1'b0;
    repeat (4) @(negedge clk);
    bad = 0;
    for (int i = 94; i < 128; i++) if (mem[i] !== 8'hA5) bad++;
    check("abort_mem_untouched", bad, 0);
    check("abort_idle_after", busy, 0);
    $display("frame aborted by init at write 30");
  endtask

  task automatic back_to_back();
    int lat;
    bit seen, busy_ok;
    fill_msg();
    push_frame(3'd2, 6'h15, 4'd10);
    push_frame(3'd5, 6'h3A, 4'd7);
    @(negedge clk);
    pat_sel = 3'd2; seed = 6'h15; pre_len = 4'd10; start = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 30) begin pat_sel = 3'd5; seed = 6'h3A; pre_len = 4'd7; end
      if (done === 1'b1) seen = 1;
    end
    check("b2b_first_latency", lat, FRAME_LEN + 2);
    lat = 0; seen = 0; busy_ok = 1;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) seen = 1;
    end
    check("b2b_second_latency", lat, FRAME_LEN + 2);
    check("b2b_no_idle", busy_ok, 1);
    @(negedge clk);
    check("b2b_idle_after", busy, 0);
    check("b2b_queue_drained", exp_q.size(), 0);
    $display("back-to-back frames completed");
  endtask

  logic [7:0] golden [7];

  initial begin
    init = 1'b1; start = 1'b0; pat_sel = 3'd0; seed = 6'd0; pre_len = 4'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    fork
      mem_writer();
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_raddr", raddr, MSG_BASE);
    check("rst_waddr", waddr, CT_BASE);
    check("rst_data_in", data_in, 0);
    init = 1'b0;
    repeat (4) @(negedge clk);

    // Known-answer frame.
    golden = '{8'h5E, 8'h5C, 8'h58, 8'h50, 8'h40, 8'h60, 8'h61};
    fill_msg();
    run_frame(3'd0, 6'h01, 4'd8, 1'b0);
    for (int i = 0; i < 7; i++) check("known_answer", mem[64 + i], golden[i]);

    // Round trip over every tap pattern.
    for (int ps = 0; ps < 6; ps++) begin
      fill_msg();
      run_frame(3'(ps), 6'($urandom_range(1, 63)), 4'($urandom_range(0, 15)), ps == 2);
      roundtrip_check(last_plc);
    end

    // Rejected requests.
    err_request(3'd6, 6'h11);
    err_request(3'd3, 6'h00);
    err_request(3'd7, 6'h00);

    // Preamble clamping.
    fill_msg();
    msg_buf[0] = 8'h00; mem[0] = 8'h00;
    run_frame(3'd4, 6'($urandom_range(1, 63)), 4'd3, 1'b0);
    roundtrip_check(7);
    fill_msg();
    msg_buf[0] = 8'h00; mem[0] = 8'h00;
    run_frame(3'd1, 6'($urandom_range(1, 63)), 4'd15, 1'b0);
    roundtrip_check(12);

    // Abort by reset, then a normal frame.
    abort_frame();
    fill_msg();
    run_frame(3'd3, 6'($urandom_range(1, 63)), 4'd11, 1'b0);
    roundtrip_check(last_plc);

    // Held start across FIN.
    back_to_back();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
